// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read port between fetch stage and imem
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch stage with stall and redirect
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    instr_fetch_if.master      imem,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        pc_out,
    output logic [6:0]         opcode,
    output logic [4:0]         rd,
    output logic [2:0]         funct3,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [6:0]         funct7,
    output logic [11:0]        csr
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        drop;
    logic        req;
    logic [31:0] redirect_aligned;
    logic        in_wait;
    logic        capture;

    assign redirect_aligned = redirect_pc & ~32'h3;
    assign in_wait          = (state == ST_WAIT);
    assign capture          = in_wait && imem.imem_rvalid && !drop && !redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:   state_next = ST_FETCH;
            ST_FETCH: state_next = req ? ST_WAIT : ST_FETCH;
            // Any response (captured, stale or racing a redirect) closes the outstanding read
            ST_WAIT:  state_next = imem.imem_rvalid ? ST_FETCH : ST_WAIT;
            default:  state_next = ST_RST;
        endcase
    end

    always_comb begin
        req = 1'b0;
        if (state == ST_FETCH) begin
            req = !redirect && !(instr_valid && stall);
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            pc_out      <= 32'h0;
        end else if (redirect) begin
            pc          <= redirect_aligned;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            // A redirect while a read is still in flight must swallow that read's response
            if (in_wait) begin
                drop <= !imem.imem_rvalid;
            end
        end else if (capture) begin
            instr       <= imem.imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
        end else begin
            if (in_wait && imem.imem_rvalid && drop) begin
                drop <= 1'b0;
            end
            if (instr_valid && !stall) begin
                instr_valid <= 1'b0;
            end
        end
    end

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign csr    = instr[31:20];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] csr;

    int checks;
    int failures;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc_out      (pc_out),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .csr         (csr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;

        tick();
        tick();
        settle();
        check("rst_req",    {31'b0, bus.imem_req}, 32'h0);
        check("rst_addr",   bus.imem_addr, 32'h0);
        check("rst_valid",  {31'b0, instr_valid}, 32'h0);
        check("rst_opcode", {25'b0, opcode}, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);

        // release: one cycle in RST, then first request
        rst_n = 1'b1;
        settle();
        check("rst_state_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        settle();
        check("f0_req",  {31'b0, bus.imem_req}, 32'h1);
        check("f0_addr", bus.imem_addr, 32'h0);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0010_0093;
        settle();
        check("w0_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("c0_valid",  {31'b0, instr_valid}, 32'h1);
        check("c0_pc_out", pc_out, 32'h0);
        check("c0_opcode", {25'b0, opcode}, 32'h13);
        check("c0_rd",     {27'b0, rd}, 32'h1);
        check("f1_req",    {31'b0, bus.imem_req}, 32'h1);
        check("f1_addr",   bus.imem_addr, 32'h4);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0020_0113;
        settle();
        check("w1_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("c1_valid",  {31'b0, instr_valid}, 32'h1);
        check("c1_pc_out", pc_out, 32'h4);
        check("c1_rd",     {27'b0, rd}, 32'h2);
        check("f2_addr",   bus.imem_addr, 32'h8);

        // CSRRW captured and held under stall
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h3400_9073;
        stall           = 1'b1;
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("csr_instr",  instr, 32'h3400_9073);
        check("csr_pc_out", pc_out, 32'h8);
        check("csr_opcode", {25'b0, opcode}, 32'h73);
        check("csr_funct3", {29'b0, funct3}, 32'h1);
        check("csr_csr",    {20'b0, csr}, 32'h340);
        for (int i = 0; i < 3; i++) begin
            check("stall_req",    {31'b0, bus.imem_req}, 32'h0);
            check("stall_valid",  {31'b0, instr_valid}, 32'h1);
            check("stall_instr",  instr, 32'h3400_9073);
            check("stall_pc_out", pc_out, 32'h8);
            tick();
        end
        stall = 1'b0;
        settle();
        check("unstall_req",  {31'b0, bus.imem_req}, 32'h1);
        check("unstall_addr", bus.imem_addr, 32'hC);
        tick();
        check("unstall_valid", {31'b0, instr_valid}, 32'h0);

        // redirect during WAIT, stale response three cycles later
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        settle();
        check("rdw_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("rdw_wait_req",   {31'b0, bus.imem_req}, 32'h0);
            check("rdw_wait_valid", {31'b0, instr_valid}, 32'h0);
            tick();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("rdw_stale_valid", {31'b0, instr_valid}, 32'h0);
        check("rdw_req2",        {31'b0, bus.imem_req}, 32'h1);
        check("rdw_addr",        bus.imem_addr, 32'h0000_0100);
        tick();
        check("rdw_stale_instr", instr, 32'h0);

        // redirect racing the response
        redirect        = 1'b1;
        redirect_pc     = 32'h0000_0200;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFE_F00D;
        tick();
        redirect        = 1'b0;
        bus.imem_rvalid = 1'b0;
        settle();
        check("race_valid", {31'b0, instr_valid}, 32'h0);
        check("race_req",   {31'b0, bus.imem_req}, 32'h1);
        check("race_addr",  bus.imem_addr, 32'h0000_0200);

        // redirect in FETCH to the top word, then wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        settle();
        check("wrap_rd_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        settle();
        check("wrap_req0",  {31'b0, bus.imem_req}, 32'h1);
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0013;
        tick();
        bus.imem_rvalid = 1'b0;
        stall           = 1'b1;
        settle();
        check("wrap_valid",  {31'b0, instr_valid}, 32'h1);
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap_addr1",  bus.imem_addr, 32'h0000_0000);

        // reset while a live instruction is held
        rst_n = 1'b0;
        tick();
        stall = 1'b0;
        settle();
        check("rv_valid",  {31'b0, instr_valid}, 32'h0);
        check("rv_instr",  instr, 32'h0);
        check("rv_pc_out", pc_out, 32'h0);
        check("rv_addr",   bus.imem_addr, 32'h0);

        // rvalid in RST is ignored
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        settle();
        check("rst_rv_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("rst_rv_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_rv_req2",  {31'b0, bus.imem_req}, 32'h1);
        check("rst_rv_addr",  bus.imem_addr, 32'h0);

        // reset mid-WAIT
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("rw_req",   {31'b0, bus.imem_req}, 32'h0);
        check("rw_addr",  bus.imem_addr, 32'h0);
        check("rw_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        check("rw_req2",  {31'b0, bus.imem_req}, 32'h1);
        check("rw_addr2", bus.imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
